// File: rtl/uart_send_hs_pkg.sv
// Shared constants for the 2 Mbps debug/host UART pair.
// The receiver and transmitter both take their defaults from here.
package uart_send_hs_pkg;

    localparam int UART_BPS_CNT      = 25;
    localparam int UART_BPS_CNT_HALF = UART_BPS_CNT / 2;
    localparam int UART_FRAME_BITS   = 10;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered level and
// first-word-fall-through read data.
module uart_tx_fifo
    import uart_send_hs_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = UART_DATA_BITS
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_send_hs.sv
// 8N1 UART transmitter with byte FIFO; frames run back-to-back
// while data is queued.
module uart_send_hs
    import uart_send_hs_pkg::*;
#(
    parameter int CLK_DIV = UART_BPS_CNT,
    parameter int FIFO_AW = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               uart_txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(2 ** FIFO_AW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       rd_data;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic [FIFO_AW:0] level_nxt;

    assign tx_ready = fifo_level != DEPTH;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = bit_cnt == CNT_MAX;
    // Pop only when a new frame can start right now.
    assign pop      = (fifo_level != '0) &&
                      ((state == S_IDLE) ||
                       (state == S_STOP && bit_end));

    always_comb begin
        level_nxt = fifo_level
                  + {{FIFO_AW{1'b0}}, push}
                  - {{FIFO_AW{1'b0}}, pop};
    end

    uart_tx_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (push),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (fifo_level)
    );

    // Line output is registered from the current state, so it
    // trails the FSM by exactly one cycle for every bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift   <= rd_data;
                        state   <= S_START;
                        tx_busy <= 1'b1;
                    end else begin
                        tx_busy <= level_nxt != '0;
                    end
                end
                S_START: begin
                    uart_txd <= 1'b0;
                    tx_busy  <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    uart_txd <= shift[0];
                    tx_busy  <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    uart_txd <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift   <= rd_data;
                            state   <= S_START;
                            tx_busy <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            tx_busy <= level_nxt != '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        tx_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_send_hs.md
# uart_send_hs

High-speed 8N1 UART transmitter with a small byte FIFO, the transmit counterpart of the 2 Mbps receiver used on the debug/host link. It accepts bytes from on-chip logic over a valid/ready handshake, buffers them, and serialises them onto `uart_txd` with bit periods matching the receiver's sampling scheme (50 MHz / 25). Frames go back-to-back with no idle gap while data is queued, so host-bound bulk transfers run at full line rate.

## Interface

Parameters:
- `CLK_DIV`, 25: `sys_clk` cycles per bit (50 MHz / 2 Mbps); legal range 4..255.
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- `sys_clk`  in  1  system clock, all logic on its rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept a byte (level < depth).
- `uart_txd`  out  1  serial line, idle high, registered output.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_level`  out  FIFO_AW+1  bytes queued, excluding the frame in flight.

## Operation

- Push: byte written when `tx_valid && tx_ready` at a rising edge. `tx_valid` while `tx_ready` low is ignored; no overflow, no error flag.
- `tx_ready` = `fifo_level != 2**FIFO_AW`, derived from the registered level.
- Serialiser FSM: IDLE -> START -> DATA -> STOP -> (START if FIFO non-empty, else IDLE).
  - IDLE: `uart_txd`=1. FIFO non-empty -> pop, load shift register, go to START.
  - START: `uart_txd`=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit index counts 0..7.
  - STOP: `uart_txd`=1 for CLK_DIV cycles. On its last cycle, if the FIFO is non-empty, pop and go straight to START.
- Bit timer: counter 0..CLK_DIV-1, width ceil(log2(CLK_DIV)), reloads to 0 on each bit boundary. Every bit, including the stop bit, is exactly CLK_DIV cycles.
- Push and pop in the same cycle: level unchanged, both take effect. Push while full cannot happen because ready is low. Pop while empty cannot happen because it is gated.
- Reset, including mid-frame: the frame is truncated, the FIFO is flushed, FSM goes to IDLE, and `uart_txd` returns high on the next edge.

## Timing

- Reset values: `uart_txd`=1, `tx_ready`=1, `tx_busy`=0, `fifo_level`=0, FSM=IDLE.
- Latency: byte accepted at edge E into an empty, idle block -> `fifo_level`=1 after E -> pop at E+1 -> `uart_txd` falls after edge E+2.
- Frame length: 10*CLK_DIV cycles (250 at default). Back-to-back frames are exactly 10*CLK_DIV cycles apart, with zero idle cycles.
- `tx_busy` falls on the edge where the STOP bit completes with the FIFO empty.
- The receiver samples at k*CLK_DIV + CLK_DIV/2 after the start edge, so mid-bit margin is ±CLK_DIV/2 cycles.

## Structure

- Shared package/include holds `UART_BPS_CNT` (25), `UART_BPS_CNT_HALF` (12) and `UART_FRAME_BITS` (10). The receiver and this block both take their defaults from it.
- FSM state encodings stay local.
- One sub-module, `uart_tx_fifo`: synchronous single-clock FIFO with registered level, `wr_en`/`rd_en`, and first-word-fall-through read data. The top holds only the FSM, bit timer and shift register.

## Test plan

- Single byte 0xA5 into idle block -> `uart_txd` low at E+2 for 25 cycles, then 1,0,1,0,0,1,0,1 (LSB first) at 25 cycles each, then high 25 cycles; `tx_busy` 0 afterwards.
- Two bytes 0x00, 0xFF pushed on consecutive cycles -> second start bit begins exactly 250 cycles after the first; no idle cycle between frames.
- 17 consecutive pushes while idle -> byte 0 is popped, `fifo_level` reaches 16 and `tx_ready` goes 0; the 17th is either accepted or ignored per ready. All accepted bytes come out in order, and none are duplicated.
- Assert `sys_rst` during data bit 3 of a frame -> `uart_txd`=1 next edge, `fifo_level`=0, `tx_ready`=1; a fresh 0x3C then transmits correctly.
- Loopback into the 2 Mbps receiver, 256 random bytes streamed with random `tx_valid` gaps -> every byte received matches, one `uart_rec` pulse per byte.
- `CLK_DIV`=4 build, byte 0x81 -> each bit is 4 cycles and the frame is 40 cycles.
